// File: rtl/channel_framer.sv
`default_nettype none
// ============================================================================
// Module      : channel_framer
// Description : Buffers a continuous payload sample stream (valid/ready) in an
//               internal FIFO and emits fixed-format frames on a valid-only
//               stream: PREAMBLE_LEN x PREAMBLE_WORD, one header word carrying
//               the frame sequence number, PAYLOAD_LEN payload words, then
//               GAP_LEN idle cycles. A frame starts only once a complete
//               payload is buffered, so the payload phase never underflows.
// Ports       : i_clock, i_reset    - clock, synchronous active-high reset
//               i_in_data/i_in_valid - payload sample input
//               o_in_ready           - FIFO has room for a sample
//               o_out_data/o_out_valid/o_out_last - framed output stream
//               o_frame_count        - frames completed since reset (wraps)
// Revision    : 1.0 - initial release
// ============================================================================
module channel_framer #(
    parameter int               WIDTH         = 16,
    parameter int               PAYLOAD_LEN   = 64,
    parameter int               PREAMBLE_LEN  = 8,
    parameter logic [WIDTH-1:0] PREAMBLE_WORD = 16'hA5A5,
    parameter int               GAP_LEN       = 4,
    parameter int               FIFO_DEPTH    = 128
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic [WIDTH-1:0] i_in_data,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    output logic [WIDTH-1:0] o_out_data,
    output logic             o_out_valid,
    output logic             o_out_last,
    output logic [WIDTH-1:0] o_frame_count
);

    // ------------------------------------------------------------------
    // Elaboration-time parameter checks
    // ------------------------------------------------------------------
    generate
        if (PAYLOAD_LEN < 1 || PAYLOAD_LEN > FIFO_DEPTH) begin : g_bad_payload_len
            $error("channel_framer: PAYLOAD_LEN must be in 1..FIFO_DEPTH");
        end
        if (PREAMBLE_LEN < 1) begin : g_bad_preamble_len
            $error("channel_framer: PREAMBLE_LEN must be at least 1");
        end
        if (GAP_LEN < 0) begin : g_bad_gap_len
            $error("channel_framer: GAP_LEN must not be negative");
        end
        if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_fifo_depth
            $error("channel_framer: FIFO_DEPTH must be a power of 2 (>= 2)");
        end
    endgenerate

    // ------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------
    localparam int c_PTR_W     = $clog2(FIFO_DEPTH);
    // One extra bit so that "full" (FIFO_DEPTH) is distinct from "empty".
    localparam int c_CNT_W     = c_PTR_W + 1;
    localparam int c_MAX_A     = (PAYLOAD_LEN > PREAMBLE_LEN) ? PAYLOAD_LEN : PREAMBLE_LEN;
    localparam int c_PHASE_MAX = (c_MAX_A > GAP_LEN) ? c_MAX_A : GAP_LEN;
    localparam int c_PHASE_W   = $clog2(c_PHASE_MAX + 1);

    localparam logic [c_PTR_W-1:0]   c_PTR_ONE   = c_PTR_W'(1);
    localparam logic [c_CNT_W-1:0]   c_CNT_ONE   = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0]   c_CNT_FULL  = c_CNT_W'(FIFO_DEPTH);
    localparam logic [c_CNT_W-1:0]   c_CNT_FRAME = c_CNT_W'(PAYLOAD_LEN);
    localparam logic [c_PHASE_W-1:0] c_PH_ONE    = c_PHASE_W'(1);
    localparam logic [c_PHASE_W-1:0] c_PRE_LAST  = c_PHASE_W'(PREAMBLE_LEN - 1);
    localparam logic [c_PHASE_W-1:0] c_PAY_LAST  = c_PHASE_W'(PAYLOAD_LEN - 1);
    localparam logic [c_PHASE_W-1:0] c_GAP_LAST  = c_PHASE_W'((GAP_LEN > 0) ? GAP_LEN - 1 : 0);
    localparam logic [WIDTH-1:0]     c_SEQ_ONE   = WIDTH'(1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_PREAMBLE = 3'd1,
        S_HEADER   = 3'd2,
        S_PAYLOAD  = 3'd3,
        S_GAP      = 3'd4
    } state_t;

    // ------------------------------------------------------------------
    // Signals
    // ------------------------------------------------------------------
    state_t               r_state;
    state_t               w_state_next;
    logic [c_PHASE_W-1:0] r_phase;
    logic [c_PHASE_W-1:0] w_phase_next;

    logic [WIDTH-1:0]     r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_CNT_W-1:0]   r_count;
    logic [c_CNT_W-1:0]   w_count_next;
    logic                 r_in_ready;
    logic                 w_wr_en;
    logic                 w_rd_en;

    logic [WIDTH-1:0]     r_seq;
    logic [WIDTH-1:0]     r_out_data;
    logic                 r_out_valid;
    logic                 r_out_last;
    logic [WIDTH-1:0]     w_out_data;
    logic                 w_out_valid;
    logic                 w_out_last;

    // ------------------------------------------------------------------
    // FIFO bookkeeping
    // ------------------------------------------------------------------
    assign w_wr_en = i_in_valid && r_in_ready;

    always_comb begin
        w_count_next = r_count;
        case ({w_wr_en, w_rd_en})
            2'b10:   w_count_next = r_count + c_CNT_ONE;
            2'b01:   w_count_next = r_count - c_CNT_ONE;
            default: w_count_next = r_count;
        endcase
    end

    // Storage has no reset: flushing is done by clearing pointers and count.
    always_ff @(posedge i_clock) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= i_in_data;
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_in_ready <= 1'b0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_rd_en) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            r_count    <= w_count_next;
            // Ready is derived from the count the FIFO will hold after this
            // edge, so a registered ready can never admit a write when full.
            r_in_ready <= (w_count_next < c_CNT_FULL);
        end
    end

    // ------------------------------------------------------------------
    // Frame FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state <= S_IDLE;
            r_phase <= '0;
        end else begin
            r_state <= w_state_next;
            r_phase <= w_phase_next;
        end
    end

    // ------------------------------------------------------------------
    // Frame FSM: next state and output word selection
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_phase_next = r_phase;
        w_rd_en      = 1'b0;
        w_out_valid  = 1'b0;
        w_out_last   = 1'b0;
        w_out_data   = '0;

        case (r_state)
            S_IDLE: begin
                if (r_count >= c_CNT_FRAME) begin
                    w_state_next = S_PREAMBLE;
                    w_phase_next = '0;
                end
            end

            S_PREAMBLE: begin
                w_out_valid = 1'b1;
                w_out_data  = PREAMBLE_WORD;
                if (r_phase == c_PRE_LAST) begin
                    w_state_next = S_HEADER;
                    w_phase_next = '0;
                end else begin
                    w_phase_next = r_phase + c_PH_ONE;
                end
            end

            S_HEADER: begin
                w_out_valid  = 1'b1;
                w_out_data   = r_seq;
                w_state_next = S_PAYLOAD;
                w_phase_next = '0;
            end

            S_PAYLOAD: begin
                // A full payload was buffered before the frame started, so
                // the FIFO is never empty here.
                w_out_valid = 1'b1;
                w_out_data  = r_mem[r_rd_ptr];
                w_rd_en     = 1'b1;
                if (r_phase == c_PAY_LAST) begin
                    w_out_last   = 1'b1;
                    w_state_next = (GAP_LEN > 0) ? S_GAP : S_IDLE;
                    w_phase_next = '0;
                end else begin
                    w_phase_next = r_phase + c_PH_ONE;
                end
            end

            S_GAP: begin
                if (r_phase == c_GAP_LAST) begin
                    w_state_next = S_IDLE;
                    w_phase_next = '0;
                end else begin
                    w_phase_next = r_phase + c_PH_ONE;
                end
            end

            default: begin
                w_state_next = S_IDLE;
                w_phase_next = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output registers and frame sequence counter
    // ------------------------------------------------------------------
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_seq       <= '0;
        end else begin
            r_out_data  <= w_out_data;
            r_out_valid <= w_out_valid;
            r_out_last  <= w_out_last;
            // Count the frame while its last word is being presented; the
            // counter wraps naturally at 2^WIDTH.
            if (r_out_last) begin
                r_seq <= r_seq + c_SEQ_ONE;
            end
        end
    end

    assign o_in_ready    = r_in_ready;
    assign o_out_data    = r_out_data;
    assign o_out_valid   = r_out_valid;
    assign o_out_last    = r_out_last;
    assign o_frame_count = r_seq;

endmodule
`default_nettype wire
